// File: rtl/lisnoc16_converter_32to16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lisnoc16_converter_32to16 : splits 32-bit LISNoC flits into a 16-bit packet
// Revision: 1.0
// ---------------------------------------------------------------------------
module lisnoc16_converter_32to16 #(
    parameter int          vchannels_32    = 3,
    parameter int          vchannels_16    = 1,
    parameter int          use_vchannel_32 = 0,
    parameter int          use_vchannel_16 = 0,
    parameter logic [4:0]  dest16          = 5'd0,
    parameter logic [2:0]  packet16_class  = 3'd3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [33:0]             flit32_in,
    input  logic [vchannels_32-1:0] flit32_valid,
    output logic [vchannels_32-1:0] flit32_ready,
    output logic [17:0]             flit16_out,
    output logic [vchannels_16-1:0] flit16_valid,
    input  logic [vchannels_16-1:0] flit16_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t      state;
    logic [33:0] hold;

    logic        in_valid;
    logic        out_ready;
    logic        in_ready;
    logic        in_ready_gated;
    logic        out_valid;
    logic        in_xfer;
    logic        out_xfer;
    logic        lo_last;
    logic        unused_inputs;

    assign in_valid  = flit32_valid[use_vchannel_32];
    assign out_ready = flit16_ready[use_vchannel_16];
    assign unused_inputs = ^{flit32_valid, flit16_ready};

    // LAST (10) and SINGLE (11) both close the packet on the low half
    assign lo_last = hold[33];

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        flit16_out = 18'd0;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_HDR: begin
                out_valid  = 1'b1;
                flit16_out = {2'b01, dest16, packet16_class, 8'h00};
            end
            S_HI: begin
                out_valid  = 1'b1;
                flit16_out = {2'b00, hold[31:16]};
            end
            S_LO: begin
                out_valid  = 1'b1;
                flit16_out = {(lo_last ? 2'b10 : 2'b00), hold[15:0]};
                in_ready   = lo_last ? 1'b0 : out_ready;
            end
            S_WAIT: in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Ready is forced low while reset is held, even though state reads IDLE
    assign in_ready_gated = in_ready & rst;
    assign in_xfer        = in_valid & in_ready_gated;
    assign out_xfer       = out_valid & out_ready;

    for (genvar i = 0; i < vchannels_32; i++) begin : g_in_ready
        assign flit32_ready[i] = (i == use_vchannel_32) ? in_ready_gated : 1'b0;
    end

    for (genvar j = 0; j < vchannels_16; j++) begin : g_out_valid
        assign flit16_valid[j] = (j == use_vchannel_16) ? out_valid : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            hold  <= 34'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Body flits arriving without a header are discarded
                    if (in_xfer && flit32_in[32]) begin
                        hold  <= flit32_in;
                        state <= S_HDR;
                    end
                end
                S_HDR: if (out_xfer) state <= S_HI;
                S_HI:  if (out_xfer) state <= S_LO;
                S_LO: begin
                    if (out_xfer) begin
                        if (lo_last) begin
                            state <= S_IDLE;
                        end else if (in_xfer) begin
                            hold  <= flit32_in;
                            state <= S_HI;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (in_xfer) begin
                        hold  <= flit32_in;
                        state <= S_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lisnoc16_converter_32to16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lisnoc16_converter_32to16 : directed scoreboard bench for the converter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lisnoc16_converter_32to16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [33:0] flit32_in = 34'd0;
    logic [2:0]  flit32_valid = 3'd0;
    logic [2:0]  flit32_ready;
    logic [17:0] flit16_out;
    logic [0:0]  flit16_valid;
    logic [0:0]  flit16_ready = 1'b1;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        in_pkt = 1'b0;
    logic [17:0] exp_q[$];

    lisnoc16_converter_32to16 #(
        .vchannels_32   (3),
        .vchannels_16   (1),
        .use_vchannel_32(2),
        .use_vchannel_16(0),
        .dest16         (5'd5),
        .packet16_class (3'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flit32_in   (flit32_in),
        .flit32_valid(flit32_valid),
        .flit32_ready(flit32_ready),
        .flit16_out  (flit16_out),
        .flit16_valid(flit16_valid),
        .flit16_ready(flit16_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: what a newly accepted 32-bit flit must produce
    task automatic model_accept(input logic [33:0] d);
        if (!in_pkt) begin
            if (d[32]) begin
                exp_q.push_back({2'b01, 5'd5, 3'd3, 8'h00});
                exp_q.push_back({2'b00, d[31:16]});
                exp_q.push_back({(d[33] ? 2'b10 : 2'b00), d[15:0]});
                in_pkt = !d[33];
            end
        end else begin
            exp_q.push_back({2'b00, d[31:16]});
            exp_q.push_back({(d[33] ? 2'b10 : 2'b00), d[15:0]});
            in_pkt = !d[33];
        end
    endtask

    // One clock cycle: drive, settle, score outputs, advance past the edge
    task automatic do_cycle(input logic [2:0] vin, input logic [33:0] d,
                            input logic rdy, output logic accepted);
        logic [17:0] e;
        flit32_valid = vin;
        flit32_in    = d;
        flit16_ready = rdy;
        #1;
        if (flit16_valid[0] && flit16_ready[0]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {16'd0, flit16_out}, 34'h3FFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_out", {16'd0, flit16_out}, {16'd0, e});
            end
        end
        accepted = flit32_valid[2] && flit32_ready[2];
        if (accepted) model_accept(d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [33:0] d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            do_cycle(3'b100, d, 1'b1, acc);
            n++;
        end
        if (!acc) check("send_timeout", 34'd0, 34'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            do_cycle(3'b000, 34'd0, 1'b1, acc);
            n++;
        end
        check("drain_empty", 34'(exp_q.size()), 34'd0);
        #1;
        check("idle_valid", {33'd0, flit16_valid[0]}, 34'd0);
        check("idle_ready", {31'd0, flit32_ready}, 34'b100);
    endtask

    initial begin
        logic acc;
        int   c0;

        // Reset state
        #2;
        check("rst_valid", {33'd0, flit16_valid[0]}, 34'd0);
        check("rst_ready", {31'd0, flit32_ready}, 34'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, flit32_ready}, 34'b100);

        // SINGLE flit, sink always ready
        send({2'b11, 32'hDEADBEEF});
        check("hdr_latency_valid", {33'd0, flit16_valid[0]}, 34'd1);
        check("hdr_value", {16'd0, flit16_out}, {16'd0, 2'b01, 16'h2B00});
        drain();

        // Two flits back-to-back, second accepted in the LO cycle
        c0 = cyc;
        send({2'b01, 32'h12345678});
        send({2'b10, 32'h9ABCDEF0});
        check("b2b_accept_cycle", 34'(cyc - c0), 34'd4);
        check("b2b_no_bubble", {33'd0, flit16_valid[0]}, 34'd1);
        drain();

        // Sink stalls during HI
        send({2'b11, 32'hDEADBEEF});
        do_cycle(3'b000, 34'd0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            do_cycle(3'b100, {2'b01, 32'h0}, 1'b0, acc);
            check("stall_out", {16'd0, flit16_out}, {16'd0, 2'b00, 16'hDEAD});
            check("stall_in_ready", {31'd0, flit32_ready}, 34'd0);
        end
        drain();

        // Stray PAYLOAD in IDLE is swallowed
        send({2'b00, 32'hAAAA5555});
        do_cycle(3'b000, 34'd0, 1'b1, acc);
        check("stray_no_valid", {33'd0, flit16_valid[0]}, 34'd0);
        check("stray_still_idle", {31'd0, flit32_ready}, 34'b100);

        // Reset during LO of a multi-flit packet
        send({2'b01, 32'h11112222});
        do_cycle(3'b000, 34'd0, 1'b1, acc);
        do_cycle(3'b000, 34'd0, 1'b1, acc);
        check("pre_rst_lo", {16'd0, flit16_out}, {16'd0, 2'b00, 16'h2222});
        rst = 1'b0;
        #1;
        check("rst_mid_valid", {33'd0, flit16_valid[0]}, 34'd0);
        check("rst_mid_ready", {31'd0, flit32_ready}, 34'd0);
        exp_q.delete();
        in_pkt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        send({2'b11, 32'h01020304});
        drain();

        // Valid on unused VCs is ignored
        for (int i = 0; i < 3; i++) begin
            do_cycle(3'b011, {2'b01, 32'hCAFEF00D}, 1'b1, acc);
            check("vc_ready_low", {32'd0, flit32_ready[1:0]}, 34'd0);
            check("vc_no_output", {33'd0, flit16_valid[0]}, 34'd0);
        end
        check("vc_queue_empty", 34'(exp_q.size()), 34'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lisnoc16_converter_32to16.md
LISNOC16_CONVERTER_32TO16 -- requirements
Module: lisnoc16_converter_32to16

Interface
REQ-001 SHALL have parameter vchannels_32, default 3, number of VCs on the 32-bit input side.
REQ-002 SHALL have parameter vchannels_16, default 1, number of VCs on the 16-bit output side.
REQ-003 SHALL have parameter use_vchannel_32, default 0, the only 32-bit VC consumed.
REQ-004 SHALL have parameter use_vchannel_16, default 0, the only 16-bit VC driven.
REQ-005 SHALL have parameter dest16, default 5'd0, 16-bit-network destination written into each generated header.
REQ-006 SHALL have parameter packet16_class, default 3'd3, class written into each generated header.
REQ-007 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-009 SHALL have port flit32_in, input, 34: [33:32] type, [31:0] data.
REQ-010 SHALL have port flit32_valid, input, vchannels_32: per-VC valid.
REQ-011 SHALL have port flit32_ready, output, vchannels_32: per-VC ready.
REQ-012 SHALL have port flit16_out, output, 18: [17:16] type, [15:0] data.
REQ-013 SHALL have port flit16_valid, output, vchannels_16: per-VC valid.
REQ-014 SHALL have port flit16_ready, input, vchannels_16: per-VC ready.

Function
REQ-015 SHALL use type encoding PAYLOAD=00, HEADER=01, LAST=10, SINGLE=11 on both sides.
REQ-016 SHALL use only VC use_vchannel_32 on input and VC use_vchannel_16 on output; all other ready/valid bits SHALL be 0.
REQ-017 SHALL perform a transfer on a port only in a cycle where valid and ready are both 1.
REQ-018 SHALL hold one 34-bit register (hold) for the accepted 32-bit flit; flit16_out and flit16_valid SHALL be driven only from state and hold, with no combinational path from flit16_ready to flit16_valid.
REQ-019 SHALL implement states IDLE, HDR, HI, LO, WAIT.
REQ-020 IDLE: flit32_ready=1, flit16_valid=0; an accepted HEADER or SINGLE flit SHALL load hold and go to HDR; an accepted PAYLOAD or LAST flit SHALL be dropped, state remaining IDLE.
REQ-021 HDR: flit16_out={01, dest16, packet16_class, 8'h00} (data [15:11] dest, [10:8] class, [7:0] zero), valid=1, flit32_ready=0; on transfer go to HI.
REQ-022 HI: flit16_out={00, hold[31:16]}, valid=1, flit32_ready=0; on transfer go to LO.
REQ-023 LO: flit16_out={t, hold[15:0]}, t=10 if hold type is LAST or SINGLE, else 00; valid=1.
REQ-024 LO with t=10: flit32_ready=0; on transfer go to IDLE.
REQ-025 LO with t=00: flit32_ready=flit16_ready; on output transfer with simultaneous input transfer, load hold and go to HI; on output transfer alone go to WAIT.
REQ-026 WAIT: flit32_ready=1, valid=0; an accepted flit SHALL load hold and go to HI.
REQ-027 A HEADER or SINGLE flit accepted in LO or WAIT SHALL be treated as a body flit; its type SHALL only decide t at LO.
REQ-028 While valid=1 and ready=0, flit16_out SHALL remain stable.
REQ-029 Latency SHALL be 1 cycle from 32-bit header acceptance to the 16-bit header appearing; a packet of N 32-bit flits SHALL produce 2N+1 16-bit flits.

Reset
REQ-030 On rst low, state SHALL become IDLE and hold SHALL become 0, asynchronously.
REQ-031 During reset, flit16_valid SHALL be 0 and flit32_ready SHALL be 0.
REQ-032 A packet interrupted by reset SHALL be discarded; after release, the first accepted flit SHALL be handled as in IDLE.

Verification
REQ-033 dest16=5, class=3, input {11,DEADBEEF}, sink always ready -> output {01,2B00}, {00,DEAD}, {10,BEEF} on consecutive cycles, then IDLE.
REQ-034 Input {01,12345678}, {10,9ABCDEF0} offered back-to-back -> output {01,2B00}, {00,1234}, {00,5678}, {00,9ABC}, {10,DEF0} with no bubble; second flit accepted in the LO cycle.
REQ-035 flit16_ready low for 3 cycles during HI of REQ-033 -> {00,DEAD} held stable for 4 cycles with flit32_ready=0, then the sequence continues.
REQ-036 Input {00,AAAA5555} in IDLE -> accepted (flit32_ready=1), flit16_valid stays 0, state stays IDLE.
REQ-037 rst asserted during LO of a multi-flit packet -> flit16_valid=0 immediately; after release, {11,01020304} -> {01,2B00}, {00,0102}, {10,0304}.
REQ-038 vchannels_32=3, use_vchannel_32=2 -> flit32_ready[1:0]=0 always; valid on VC0 or VC1 is ignored.
